pin_bus_master: RTL and testbench

- Parametrised successor to the free-running counter master: a real pin-bus master.
- Accepts burst commands on a valid/ready port and drives the req/rw/address/wr_data pin bus beat by beat.
- Collects ack/err/rd_data per beat, enforces a per-beat timeout, and keeps transaction and error counters.
- Sits between a stimulus/CPU-side source and the pin_if master modport.

---
 rtl/pin_bus_master.sv | 174 +++++++++++++++++
 tb/tb_pin_bus_master.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_bus_master.sv
// pin_bus_master: burst master for the req/ack pin bus.
//
// Takes one command at a time on a valid/ready port and plays it out on the
// bus one beat at a time. Each beat holds req until ack or err is sampled, or
// until the per-beat timeout expires. Every finished beat produces a one-cycle
// response. An errored or timed-out beat ends the burst early.
//
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only when idle)
//   cmd_rw/addr/wdata/len         direction, first address, first data, beats-1
//   address/wr_data/rw/req        pin-bus master outputs
//   rd_data/ack/err               pin-bus slave inputs
//   rsp_valid/rdata/err/timeout/last  per-beat response pulse
//   busy                          high whenever a command is in progress
//   txn_count/err_count           completed commands (wraps) / bad beats (saturates)
module pin_bus_master #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DW         = 8,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned ADDR_INC   = 1,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DW-1:0]         cmd_wdata,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DW-1:0]         wr_data,
    input  logic [DW-1:0]         rd_data,
    output logic                  rw,
    output logic                  req,
    input  logic                  ack,
    input  logic                  err,
    output logic                  rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  rsp_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  txn_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    // Wait counter only has to reach TIMEOUT-1.
    localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic                  rw_q, rw_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  to_q, to_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic [CNT_WIDTH-1:0]  txn_q, txn_d;
    logic [CNT_WIDTH-1:0]  errc_q, errc_d;
    logic                  last;

    // Burst ends on the final beat or on the first bad beat.
    assign last = err_q || to_q || (len_q == '0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        len_d   = len_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        to_d    = to_q;
        wait_d  = wait_q;
        txn_d   = txn_q;
        errc_d  = errc_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = StReq;
                    addr_d  = cmd_addr;
                    rw_d    = cmd_rw;
                    wdata_d = cmd_rw ? cmd_wdata : '0;
                    len_d   = cmd_len;
                    wait_d  = '0;
                end
            end
            StReq: begin
                // ack+err together is reported as err.
                if (ack || err) begin
                    state_d = StResp;
                    rdata_d = rd_data;
                    err_d   = err;
                    to_d    = 1'b0;
                end else if (TIMEOUT != 0 && wait_q == WW'(TIMEOUT - 1)) begin
                    state_d = StResp;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    to_d    = 1'b1;
                end else if (TIMEOUT != 0) begin
                    wait_d = wait_q + WW'(1);
                end
            end
            StResp: begin
                if (last) begin
                    state_d = StIdle;
                    txn_d   = txn_q + CNT_WIDTH'(1);
                end else begin
                    state_d = StReq;
                    addr_d  = addr_q + ADDR_WIDTH'(ADDR_INC);
                    if (rw_q) begin
                        wdata_d = wdata_q + DW'(1);
                    end
                    len_d  = len_q - LEN_WIDTH'(1);
                    wait_d = '0;
                end
                if ((err_q || to_q) && errc_q != '1) begin
                    errc_d = errc_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            len_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            wait_q  <= '0;
            txn_q   <= '0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            len_q   <= len_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            to_q    <= to_d;
            wait_q  <= wait_d;
            txn_q   <= txn_d;
            errc_q  <= errc_d;
        end
    end

    // req comes straight from the state register so async reset drops it at once.
    assign req         = (state_q == StReq);
    assign cmd_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign rsp_valid   = (state_q == StResp);
    assign rsp_rdata   = rsp_valid ? rdata_q : '0;
    assign rsp_err     = rsp_valid && err_q;
    assign rsp_timeout = rsp_valid && to_q;
    assign rsp_last    = rsp_valid && last;
    assign address     = addr_q;
    assign wr_data     = wdata_q;
    assign rw          = rw_q;
    assign txn_count   = txn_q;
    assign err_count   = errc_q;

endmodule

// File: tb/tb_pin_bus_master.sv
`timescale 1ns/1ps
module tb_pin_bus_master;

    localparam logic [2:0] K_ACK  = 3'd0;
    localparam logic [2:0] K_ERR  = 3'd1;
    localparam logic [2:0] K_BOTH = 3'd2;
    localparam logic [2:0] K_NONE = 3'd3;
    localparam logic [2:0] K_HANG = 3'd4;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
        logic       to;
        logic       last;
    } rsp_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wdata;
        logic [2:0]  kind;
        logic [3:0]  delay;
        logic [7:0]  rdata;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main DUT (defaults)
    logic        cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic [3:0]  cmd_len = '0;
    logic [15:0] address;
    logic [7:0]  wr_data, rd_data;
    logic        rw, req, ack, err;
    logic        rsp_valid, rsp_err, rsp_timeout, rsp_last, busy;
    logic [7:0]  rsp_rdata;
    logic [15:0] txn_count, err_count;

    pin_bus_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .address(address), .wr_data(wr_data), .rd_data(rd_data), .rw(rw),
        .req(req), .ack(ack), .err(err),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .rsp_last(rsp_last), .busy(busy),
        .txn_count(txn_count), .err_count(err_count)
    );

    // Small-counter DUT
    logic        b_rst = 1'b1;
    logic        b_cmd_valid = 1'b0, b_cmd_ready;
    logic [15:0] b_address;
    logic [7:0]  b_wr_data;
    logic        b_rw, b_req, b_ack = 1'b0, b_err = 1'b0;
    logic        b_rsp_valid, b_rsp_err, b_rsp_timeout, b_rsp_last, b_busy;
    logic [7:0]  b_rsp_rdata;
    logic [1:0]  b_txn_count, b_err_count;

    pin_bus_master #(.CNT_WIDTH(2), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(b_rst),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_rw(1'b1),
        .cmd_addr(16'h0010), .cmd_wdata(8'h01), .cmd_len(4'd0),
        .address(b_address), .wr_data(b_wr_data), .rd_data(8'h00), .rw(b_rw),
        .req(b_req), .ack(b_ack), .err(b_err),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .rsp_timeout(b_rsp_timeout), .rsp_last(b_rsp_last), .busy(b_busy),
        .txn_count(b_txn_count), .err_count(b_err_count)
    );

    int    n_cmp = 0;
    int    n_fail = 0;
    int    n_rsp = 0;
    bit    slave_busy = 1'b0;
    rsp_t  expq[$];
    beat_t beatq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (expq.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                    check("rsp_last", 32'(rsp_last), 32'(e.last));
                    n_rsp++;
                end
            end else if (!rst) begin
                check("rsp_idle_zero", 32'({rsp_rdata, rsp_err, rsp_timeout, rsp_last}), 32'd0);
            end
        end
    end

    // Slave model: plays queued beat behaviours and checks bus fields.
    initial begin
        beat_t b;
        int    cnt;
        ack = 1'b0;
        err = 1'b0;
        rd_data = 8'hC3;
        forever begin
            @(negedge clk);
            if (req && !rst) begin
                slave_busy = 1'b1;
                if (beatq.size() == 0) begin
                    check("unexpected_req", 32'(req), 32'd0);
                    for (int i = 0; i < 100 && req; i++) @(negedge clk);
                end else begin
                    b = beatq.pop_front();
                    check("beat_addr", 32'(address), 32'(b.addr));
                    check("beat_rw", 32'(rw), 32'(b.rw));
                    check("beat_wdata", 32'(wr_data), 32'(b.wdata));
                    if (b.kind == K_NONE) begin
                        cnt = 1;
                        for (int i = 0; i < 100 && req; i++) begin
                            @(negedge clk);
                            if (req) cnt++;
                        end
                        check("timeout_req_cycles", 32'(cnt), 32'd16);
                        // Late ack while req is low must be ignored.
                        ack = 1'b1;
                        @(negedge clk);
                        @(negedge clk);
                        check("late_ack_no_req", 32'(req), 32'd0);
                        check("late_ack_idle", 32'(busy), 32'd0);
                        ack = 1'b0;
                    end else if (b.kind == K_HANG) begin
                        for (int i = 0; i < 100 && req; i++) @(negedge clk);
                    end else begin
                        for (int i = 0; i < int'(b.delay); i++) begin
                            @(negedge clk);
                            check("addr_stable", 32'(address), 32'(b.addr));
                            check("wdata_stable", 32'(wr_data), 32'(b.wdata));
                            check("req_held", 32'(req), 32'd1);
                        end
                        ack = (b.kind != K_ERR);
                        err = (b.kind != K_ACK);
                        rd_data = b.rdata;
                        @(negedge clk);
                        check("req_dropped", 32'(req), 32'd0);
                        ack = 1'b0;
                        err = 1'b0;
                    end
                end
                slave_busy = 1'b0;
            end
        end
    end

    task automatic issue(input logic rw_i, input logic [15:0] a, input logic [7:0] d,
                         input logic [3:0] l);
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_rw = rw_i;
        cmd_addr = a;
        cmd_wdata = d;
        cmd_len = l;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy && expq.size() == 0 && beatq.size() == 0 && !slave_busy) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic b_cmd(input logic do_err);
        @(negedge clk);
        b_cmd_valid = 1'b1;
        @(negedge clk);
        b_cmd_valid = 1'b0;
        check("b_req", 32'(b_req), 32'd1);
        b_ack = !do_err;
        b_err = do_err;
        @(negedge clk);
        b_ack = 1'b0;
        b_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        int base;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_req", 32'(req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_txn", 32'(txn_count), 32'd0);
        check("rst_errc", 32'(err_count), 32'd0);
        rst = 1'b0;
        b_rst = 1'b0;

        // Single write, ack after 2 cycles
        beatq.push_back('{16'h1234, 1'b1, 8'hA5, K_ACK, 4'd2, 8'h00});
        expq.push_back('{8'h00, 1'b0, 1'b0, 1'b1});
        issue(1'b1, 16'h1234, 8'hA5, 4'd0);
        wait_idle("wr1_done");
        check("wr1_txn", 32'(txn_count), 32'd1);

        // Read burst with address wrap
        beatq.push_back('{16'hFFFE, 1'b0, 8'h00, K_ACK, 4'd0, 8'h10});
        beatq.push_back('{16'hFFFF, 1'b0, 8'h00, K_ACK, 4'd0, 8'h11});
        beatq.push_back('{16'h0000, 1'b0, 8'h00, K_ACK, 4'd0, 8'h12});
        beatq.push_back('{16'h0001, 1'b0, 8'h00, K_ACK, 4'd0, 8'h13});
        expq.push_back('{8'h10, 1'b0, 1'b0, 1'b0});
        expq.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
        expq.push_back('{8'h12, 1'b0, 1'b0, 1'b0});
        expq.push_back('{8'h13, 1'b0, 1'b0, 1'b1});
        issue(1'b0, 16'hFFFE, 8'h77, 4'd3);
        wait_idle("rd4_done");
        check("rd4_txn", 32'(txn_count), 32'd2);

        // Write burst aborted by err on beat 2
        beatq.push_back('{16'h0100, 1'b1, 8'hFE, K_ACK, 4'd1, 8'h00});
        beatq.push_back('{16'h0101, 1'b1, 8'hFF, K_ERR, 4'd0, 8'h5A});
        expq.push_back('{8'h00, 1'b0, 1'b0, 1'b0});
        expq.push_back('{8'h5A, 1'b1, 1'b0, 1'b1});
        issue(1'b1, 16'h0100, 8'hFE, 4'd2);
        wait_idle("werr_done");
        check("werr_txn", 32'(txn_count), 32'd3);
        check("werr_errc", 32'(err_count), 32'd1);

        // Timeout, then a late ack
        beatq.push_back('{16'h0200, 1'b0, 8'h00, K_NONE, 4'd0, 8'h00});
        expq.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
        issue(1'b0, 16'h0200, 8'h00, 4'd0);
        wait_idle("to_done");
        check("to_txn", 32'(txn_count), 32'd4);
        check("to_errc", 32'(err_count), 32'd2);

        // ack and err together
        beatq.push_back('{16'h0300, 1'b1, 8'h33, K_BOTH, 4'd0, 8'h77});
        expq.push_back('{8'h77, 1'b1, 1'b0, 1'b1});
        issue(1'b1, 16'h0300, 8'h33, 4'd1);
        wait_idle("both_done");
        check("both_errc", 32'(err_count), 32'd3);

        // Reset during beat 2 of 4
        beatq.push_back('{16'h0400, 1'b0, 8'h00, K_ACK, 4'd0, 8'h01});
        beatq.push_back('{16'h0401, 1'b0, 8'h00, K_HANG, 4'd0, 8'h00});
        expq.push_back('{8'h01, 1'b0, 1'b0, 1'b0});
        base = n_rsp;
        issue(1'b0, 16'h0400, 8'h00, 4'd3);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (n_rsp > base && req) seen = 1'b1;
        end
        check("beat2_started", 32'(seen), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_req", 32'(req), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd1);
        check("arst_txn", 32'(txn_count), 32'd0);
        check("arst_errc", 32'(err_count), 32'd0);
        @(negedge clk);
        check("arst_no_rsp", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("arst_pending", 32'(expq.size() + beatq.size()), 32'd0);
        beatq.push_back('{16'h0500, 1'b1, 8'h55, K_ACK, 4'd1, 8'h00});
        expq.push_back('{8'h00, 1'b0, 1'b0, 1'b1});
        issue(1'b1, 16'h0500, 8'h55, 4'd0);
        wait_idle("post_rst_done");
        check("post_rst_txn", 32'(txn_count), 32'd1);

        // Narrow counters: saturation and wrap
        for (int i = 0; i < 5; i++) b_cmd(1'b1);
        check("b_errc_sat", 32'(b_err_count), 32'd3);
        check("b_txn_after_err", 32'(b_txn_count), 32'd1);
        @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        b_rst = 1'b0;
        for (int i = 0; i < 5; i++) b_cmd(1'b0);
        check("b_txn_wrap", 32'(b_txn_count), 32'd1);
        check("b_errc_clean", 32'(b_err_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
